// File: rtl/fivesons_game_ctrl.sv
`default_nettype none
// ==========================================================================
// fivesons_game_ctrl - 16x16 Gomoku board, cursor, turn/win/draw control
// Revision 1.0
// ==========================================================================
module fivesons_game_ctrl #(
   parameter int WIN_LEN = 5,
   parameter int START_X = 7,
   parameter int START_Y = 7
) (
   input  logic         Clck,
   input  logic         Reset,
   input  logic         mv_up,
   input  logic         mv_down,
   input  logic         mv_left,
   input  logic         mv_right,
   input  logic         place,
   output logic [511:0] board,
   output logic [1:0]   gaming_status,
   output logic [3:0]   pointer_loc_x,
   output logic [3:0]   pointer_loc_y,
   output logic         busy,
   output logic         game_draw
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SCAN    = 2'd1,
      S_RESOLVE = 2'd2
   } state_t;

   localparam logic [4:0] c_win_len = 5'(WIN_LEN);
   localparam logic [3:0] c_arm_max = 4'(WIN_LEN - 1);
   localparam logic [3:0] c_start_x = 4'(START_X);
   localparam logic [3:0] c_start_y = 4'(START_Y);

   state_t              r_state, w_state;
   logic [511:0]        r_board, w_board;
   logic [1:0]          r_status, w_status;
   logic [3:0]          r_px, w_px, r_py, w_py;
   logic                r_busy, w_busy;
   logic                r_draw, w_draw;
   logic [8:0]          r_count, w_count;
   logic [3:0]          r_ox, w_ox, r_oy, w_oy;
   logic [1:0]          r_colour, w_colour;
   logic [1:0]          r_dir, w_dir;
   logic                r_neg, w_neg;
   logic signed [5:0]   r_cx, w_cx, r_cy, w_cy;
   logic [3:0]          r_arm_cnt, w_arm_cnt;
   logic [4:0]          r_total, w_total;
   logic                r_win, w_win;
   logic                w_arm_end;
   logic [1:0]          w_next_dir;

   logic                w_inb;
   logic [8:0]          w_scan_idx, w_cur_idx;
   logic [1:0]          w_scan_cell, w_cur_cell;
   logic                w_match;

   // Direction table: 0:(1,0) 1:(0,1) 2:(1,1) 3:(1,-1)
   function automatic logic signed [5:0] f_dx(input logic [1:0] d);
      return (d == 2'd1) ? 6'sd0 : 6'sd1;
   endfunction

   function automatic logic signed [5:0] f_dy(input logic [1:0] d);
      case (d)
         2'd0:    return 6'sd0;
         2'd3:    return -6'sd1;
         default: return 6'sd1;
      endcase
   endfunction

   // Cell (x,y) lives at bit index x*2 + y*32, i.e. {y, x, 0}
   assign w_inb       = (r_cx[5:4] == 2'b00) && (r_cy[5:4] == 2'b00);
   assign w_scan_idx  = {r_cy[3:0], r_cx[3:0], 1'b0};
   assign w_cur_idx   = {r_py, r_px, 1'b0};
   assign w_scan_cell = r_board[w_scan_idx +: 2];
   assign w_cur_cell  = r_board[w_cur_idx +: 2];
   assign w_match     = w_inb && (w_scan_cell == r_colour);

   always_ff @(posedge Clck) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_board   <= '0;
         r_status  <= 2'b00;
         r_px      <= c_start_x;
         r_py      <= c_start_y;
         r_busy    <= 1'b0;
         r_draw    <= 1'b0;
         r_count   <= 9'd0;
         r_ox      <= 4'd0;
         r_oy      <= 4'd0;
         r_colour  <= 2'b00;
         r_dir     <= 2'd0;
         r_neg     <= 1'b0;
         r_cx      <= 6'sd0;
         r_cy      <= 6'sd0;
         r_arm_cnt <= 4'd0;
         r_total   <= 5'd0;
         r_win     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_board   <= w_board;
         r_status  <= w_status;
         r_px      <= w_px;
         r_py      <= w_py;
         r_busy    <= w_busy;
         r_draw    <= w_draw;
         r_count   <= w_count;
         r_ox      <= w_ox;
         r_oy      <= w_oy;
         r_colour  <= w_colour;
         r_dir     <= w_dir;
         r_neg     <= w_neg;
         r_cx      <= w_cx;
         r_cy      <= w_cy;
         r_arm_cnt <= w_arm_cnt;
         r_total   <= w_total;
         r_win     <= w_win;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_board    = r_board;
      w_status   = r_status;
      w_px       = r_px;
      w_py       = r_py;
      w_busy     = r_busy;
      w_draw     = r_draw;
      w_count    = r_count;
      w_ox       = r_ox;
      w_oy       = r_oy;
      w_colour   = r_colour;
      w_dir      = r_dir;
      w_neg      = r_neg;
      w_cx       = r_cx;
      w_cy       = r_cy;
      w_arm_cnt  = r_arm_cnt;
      w_total    = r_total;
      w_win      = r_win;
      w_arm_end  = 1'b0;
      w_next_dir = r_dir + 2'd1;

      case (r_state)
         S_IDLE: begin
            if (mv_left && !mv_right && r_px != 4'd0)
               w_px = r_px - 4'd1;
            else if (mv_right && !mv_left && r_px != 4'd15)
               w_px = r_px + 4'd1;
            if (mv_up && !mv_down && r_py != 4'd0)
               w_py = r_py - 4'd1;
            else if (mv_down && !mv_up && r_py != 4'd15)
               w_py = r_py + 4'd1;

            // Placement uses the pre-move cursor even if a move is pulsed too
            if (place && !r_status[1] && !r_draw && w_cur_cell == 2'b00) begin
               w_colour              = r_status[0] ? 2'b10 : 2'b01;
               w_board[w_cur_idx +: 2] = w_colour;
               w_ox      = r_px;
               w_oy      = r_py;
               w_count   = r_count + 9'd1;
               w_busy    = 1'b1;
               w_dir     = 2'd0;
               w_neg     = 1'b0;
               w_arm_cnt = 4'd0;
               w_total   = 5'd1;
               w_win     = 1'b0;
               w_cx      = $signed({2'b00, r_px}) + 6'sd1;
               w_cy      = $signed({2'b00, r_py});
               w_state   = S_SCAN;
            end
         end

         S_SCAN: begin
            if (w_match) begin
               w_arm_cnt = r_arm_cnt + 4'd1;
               w_total   = r_total + 5'd1;
               if (r_total + 5'd1 >= c_win_len) begin
                  w_win   = 1'b1;
                  w_state = S_RESOLVE;
               end else if (r_arm_cnt + 4'd1 == c_arm_max) begin
                  w_arm_end = 1'b1;
               end else begin
                  w_cx = r_neg ? (r_cx - f_dx(r_dir)) : (r_cx + f_dx(r_dir));
                  w_cy = r_neg ? (r_cy - f_dy(r_dir)) : (r_cy + f_dy(r_dir));
               end
            end else begin
               w_arm_end = 1'b1;
            end

            if (w_arm_end) begin
               w_arm_cnt = 4'd0;
               if (!r_neg) begin
                  w_neg = 1'b1;
                  w_cx  = $signed({2'b00, r_ox}) - f_dx(r_dir);
                  w_cy  = $signed({2'b00, r_oy}) - f_dy(r_dir);
               end else if (r_dir == 2'd3) begin
                  w_state = S_RESOLVE;
               end else begin
                  w_dir   = w_next_dir;
                  w_neg   = 1'b0;
                  w_total = 5'd1;
                  w_cx    = $signed({2'b00, r_ox}) + f_dx(w_next_dir);
                  w_cy    = $signed({2'b00, r_oy}) + f_dy(w_next_dir);
               end
            end
         end

         S_RESOLVE: begin
            if (r_win)
               w_status = {1'b1, r_colour == 2'b10};
            else if (r_count == 9'd256)
               w_draw = 1'b1;
            else
               w_status = {r_status[1], ~r_status[0]};
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end

         default: begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end
      endcase
   end

   assign board         = r_board;
   assign gaming_status = r_status;
   assign pointer_loc_x = r_px;
   assign pointer_loc_y = r_py;
   assign busy          = r_busy;
   assign game_draw     = r_draw;

endmodule
`default_nettype wire

// File: tb/tb_fivesons_game_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_fivesons_game_ctrl - directed self-checking bench for fivesons_game_ctrl
// Revision 1.0
// ==========================================================================
module tb_fivesons_game_ctrl;

   localparam logic [4:0] P_UP    = 5'b10000;
   localparam logic [4:0] P_DOWN  = 5'b01000;
   localparam logic [4:0] P_LEFT  = 5'b00100;
   localparam logic [4:0] P_RIGHT = 5'b00010;
   localparam logic [4:0] P_PLACE = 5'b00001;

   logic         Clck = 1'b0;
   logic         Reset = 1'b1;
   logic         mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0, place = 1'b0;
   logic [511:0] board;
   logic [1:0]   gaming_status;
   logic [3:0]   pointer_loc_x, pointer_loc_y;
   logic         busy, game_draw;

   int           n_cmp = 0;
   int           n_fail = 0;
   int           m_x = 7, m_y = 7;
   logic [511:0] exp_board = '0;

   fivesons_game_ctrl #(.WIN_LEN(5), .START_X(7), .START_Y(7)) dut (
      .Clck(Clck), .Reset(Reset),
      .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
      .place(place), .board(board), .gaming_status(gaming_status),
      .pointer_loc_x(pointer_loc_x), .pointer_loc_y(pointer_loc_y),
      .busy(busy), .game_draw(game_draw)
   );

   always #5 Clck = ~Clck;

   task automatic pulse(input logic [4:0] v);
      @(negedge Clck);
      {mv_up, mv_down, mv_left, mv_right, place} = v;
      @(posedge Clck);
      #1;
      {mv_up, mv_down, mv_left, mv_right, place} = 5'b00000;
   endtask

   // Cursor move with the bench's own saturating cursor model
   task automatic mv(input logic [4:0] v);
      pulse(v);
      if (v[4] && !v[3] && m_y > 0) m_y--;
      else if (v[3] && !v[4] && m_y < 15) m_y++;
      if (v[2] && !v[1] && m_x > 0) m_x--;
      else if (v[1] && !v[2] && m_x < 15) m_x++;
   endtask

   task automatic goto(input int x, input int y);
      while (m_x < x) mv(P_RIGHT);
      while (m_x > x) mv(P_LEFT);
      while (m_y < y) mv(P_DOWN);
      while (m_y > y) mv(P_UP);
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(posedge Clck);
         #1;
      end
      n_cmp++;
      if (cyc >= 200) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cyc);
      end
   endtask

   task automatic place_at(input int x, input int y, output int cyc);
      goto(x, y);
      pulse(P_PLACE);
      wait_idle(cyc);
   endtask

   task automatic put(input int x, input int y, input logic [1:0] v);
      exp_board[x*2 + y*32 +: 2] = v;
   endtask

   task automatic do_reset();
      @(negedge Clck);
      Reset = 1'b0;
      @(posedge Clck);
      #1;
      Reset = 1'b1;
      m_x = 7;
      m_y = 7;
      exp_board = '0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (board !== '0) begin n_fail++; $display("FAIL reset_board: got %h required 0", board); end
      n_cmp++; if (gaming_status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b required 00", gaming_status); end
      n_cmp++; if (pointer_loc_x !== 4'd7) begin n_fail++; $display("FAIL reset_x: got %0d required 7", pointer_loc_x); end
      n_cmp++; if (pointer_loc_y !== 4'd7) begin n_fail++; $display("FAIL reset_y: got %0d required 7", pointer_loc_y); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_cmp++; if (game_draw !== 1'b0) begin n_fail++; $display("FAIL reset_draw: got %b required 0", game_draw); end
   endtask

   task automatic test_cursor();
      for (int i = 0; i < 10; i++) mv(P_LEFT);
      n_cmp++; if (pointer_loc_x !== 4'd0) begin n_fail++; $display("FAIL cursor_left_sat: got %0d required 0", pointer_loc_x); end
      mv(P_UP | P_DOWN);
      n_cmp++; if (pointer_loc_y !== 4'd7) begin n_fail++; $display("FAIL cursor_updown: got %0d required 7", pointer_loc_y); end
      for (int i = 0; i < 20; i++) mv(P_RIGHT);
      n_cmp++; if (pointer_loc_x !== 4'd15) begin n_fail++; $display("FAIL cursor_right_sat: got %0d required 15", pointer_loc_x); end
      mv(P_LEFT | P_RIGHT);
      n_cmp++; if (pointer_loc_x !== 4'd15) begin n_fail++; $display("FAIL cursor_leftright: got %0d required 15", pointer_loc_x); end
      for (int i = 0; i < 10; i++) mv(P_UP);
      n_cmp++; if (pointer_loc_y !== 4'd0) begin n_fail++; $display("FAIL cursor_up_sat: got %0d required 0", pointer_loc_y); end
   endtask

   task automatic test_isolated_place();
      int cyc;
      do_reset();
      pulse(P_PLACE);
      put(7, 7, 2'b01);
      n_cmp++; if (board[239:238] !== 2'b01) begin n_fail++; $display("FAIL iso_cell: got %b required 01", board[239:238]); end
      n_cmp++; if (board !== exp_board) begin n_fail++; $display("FAIL iso_board: got %h required %h", board, exp_board); end
      wait_idle(cyc);
      n_cmp++; if (cyc != 9) begin n_fail++; $display("FAIL iso_busy_cycles: got %0d required 9", cyc); end
      n_cmp++; if (gaming_status !== 2'b01) begin n_fail++; $display("FAIL iso_status: got %b required 01", gaming_status); end
   endtask

   task automatic test_occupied_busy();
      int cyc;
      pulse(P_PLACE);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL occ_busy: got %b required 0", busy); end
      n_cmp++; if (board !== exp_board) begin n_fail++; $display("FAIL occ_board: got %h required %h", board, exp_board); end
      n_cmp++; if (gaming_status !== 2'b01) begin n_fail++; $display("FAIL occ_status: got %b required 01", gaming_status); end
      goto(8, 8);
      pulse(P_PLACE);
      put(8, 8, 2'b10);
      pulse(P_RIGHT | P_PLACE);
      wait_idle(cyc);
      n_cmp++; if (pointer_loc_x !== 4'd8) begin n_fail++; $display("FAIL busy_move_x: got %0d required 8", pointer_loc_x); end
      n_cmp++; if (board !== exp_board) begin n_fail++; $display("FAIL busy_board: got %h required %h", board, exp_board); end
      n_cmp++; if (gaming_status !== 2'b00) begin n_fail++; $display("FAIL busy_status: got %b required 00", gaming_status); end
   endtask

   task automatic test_horizontal_win();
      int cyc;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         place_at(i, 0, cyc);
         put(i, 0, 2'b01);
         if (i == 3) begin
            n_cmp++; if (gaming_status !== 2'b01) begin n_fail++; $display("FAIL four_p1_status: got %b required 01", gaming_status); end
         end
         place_at(i, 5, cyc);
         put(i, 5, 2'b10);
      end
      n_cmp++; if (gaming_status !== 2'b00) begin n_fail++; $display("FAIL four_p2_status: got %b required 00", gaming_status); end
      place_at(4, 0, cyc);
      put(4, 0, 2'b01);
      n_cmp++; if (gaming_status !== 2'b10) begin n_fail++; $display("FAIL hwin_status: got %b required 10", gaming_status); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hwin_busy: got %b required 0", busy); end
      place_at(5, 5, cyc);
      n_cmp++; if (board !== exp_board) begin n_fail++; $display("FAIL hwin_reject_board: got %h required %h", board, exp_board); end
      n_cmp++; if (gaming_status !== 2'b10) begin n_fail++; $display("FAIL hwin_reject_status: got %b required 10", gaming_status); end
      mv(P_RIGHT);
      n_cmp++; if (pointer_loc_x !== 4'd6) begin n_fail++; $display("FAIL hwin_cursor: got %0d required 6", pointer_loc_x); end
   endtask

   task automatic test_antidiag_win();
      int cyc;
      int p1y[5] = '{0, 2, 4, 6, 8};
      int p2x[5] = '{4, 3, 2, 1, 0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         place_at(15, p1y[i], cyc);
         put(15, p1y[i], 2'b01);
         place_at(p2x[i], i, cyc);
         put(p2x[i], i, 2'b10);
      end
      n_cmp++; if (cyc != 11) begin n_fail++; $display("FAIL adiag_busy_cycles: got %0d required 11", cyc); end
      n_cmp++; if (gaming_status !== 2'b11) begin n_fail++; $display("FAIL adiag_status: got %b required 11", gaming_status); end
      place_at(7, 7, cyc);
      n_cmp++; if (board !== exp_board) begin n_fail++; $display("FAIL adiag_reject_board: got %h required %h", board, exp_board); end
      n_cmp++; if (gaming_status !== 2'b11) begin n_fail++; $display("FAIL adiag_reject_status: got %b required 11", gaming_status); end
   endtask

   task automatic test_reset_mid_scan();
      int cyc;
      do_reset();
      pulse(P_PLACE);
      @(posedge Clck);
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_scan_busy: got %b required 1", busy); end
      do_reset();
      n_cmp++; if (board !== '0) begin n_fail++; $display("FAIL mid_reset_board: got %h required 0", board); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
      n_cmp++; if (gaming_status !== 2'b00) begin n_fail++; $display("FAIL mid_reset_status: got %b required 00", gaming_status); end
      n_cmp++; if ({pointer_loc_x, pointer_loc_y} !== 8'h77) begin n_fail++; $display("FAIL mid_reset_ptr: got %h required 77", {pointer_loc_x, pointer_loc_y}); end
      repeat (12) @(posedge Clck);
      #1;
      n_cmp++; if (busy !== 1'b0 || gaming_status !== 2'b00) begin n_fail++; $display("FAIL mid_reset_idle: busy=%b status=%b required 0/00", busy, gaming_status); end
      pulse(P_PLACE);
      n_cmp++; if (board[239:238] !== 2'b01) begin n_fail++; $display("FAIL mid_reset_replace: got %b required 01", board[239:238]); end
      wait_idle(cyc);
   endtask

   task automatic test_draw();
      int cyc;
      int n1, n2;
      int ax1[128], ay1[128], ax2[128], ay2[128];
      do_reset();
      n1 = 0;
      n2 = 0;
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 16; x++) begin
            if (((x + 2*y) % 4) < 2) begin
               ax1[n1] = x; ay1[n1] = y; n1++;
            end else begin
               ax2[n2] = x; ay2[n2] = y; n2++;
            end
         end
      end
      for (int i = 0; i < 128; i++) begin
         place_at(ax1[i], ay1[i], cyc);
         put(ax1[i], ay1[i], 2'b01);
         if (i == 127) begin
            n_cmp++; if (game_draw !== 1'b0 || gaming_status !== 2'b01) begin n_fail++; $display("FAIL draw_early: draw=%b status=%b required 0/01", game_draw, gaming_status); end
         end
         place_at(ax2[i], ay2[i], cyc);
         put(ax2[i], ay2[i], 2'b10);
      end
      n_cmp++; if (game_draw !== 1'b1) begin n_fail++; $display("FAIL draw_flag: got %b required 1", game_draw); end
      n_cmp++; if (gaming_status !== 2'b01) begin n_fail++; $display("FAIL draw_status: got %b required 01", gaming_status); end
      n_cmp++; if (board !== exp_board) begin n_fail++; $display("FAIL draw_board: got %h required %h", board, exp_board); end
      pulse(P_PLACE);
      n_cmp++; if (busy !== 1'b0 || game_draw !== 1'b1) begin n_fail++; $display("FAIL draw_reject: busy=%b draw=%b required 0/1", busy, game_draw); end
   endtask

   initial begin
      test_reset();
      test_cursor();
      test_isolated_place();
      test_occupied_busy();
      test_horizontal_win();
      test_antidiag_win();
      test_reset_mid_scan();
      test_draw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
